// File: rtl/scalar_decode_issue_pkg.sv
// Shared definitions for the scalar decode/issue stage: opcodes,
// instruction field positions and the op-class helper.
package scalar_decode_issue_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_ADDI  = 4'd5,
    OP_LOAD  = 4'd6,
    OP_STORE = 4'd7
  } op_e;

  localparam int FIELD_W = 5;
  localparam int IMM_W   = 13;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 23;
  localparam int RS1_MSB = 22;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 13;
  localparam int IMM_MSB = 12;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic legal_op;
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } op_class_t;

  // Opcodes 8..15 are undefined and come back with legal_op clear.
  function automatic op_class_t classify_op(input logic [3:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OP_NOP: begin
        c.legal_op = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        c.legal_op  = 1'b1;
        c.uses_rs1  = 1'b1;
        c.uses_rs2  = 1'b1;
        c.writes_rd = 1'b1;
      end
      OP_ADDI, OP_LOAD: begin
        c.legal_op  = 1'b1;
        c.uses_rs1  = 1'b1;
        c.writes_rd = 1'b1;
      end
      OP_STORE: begin
        c.legal_op = 1'b1;
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // A register field is legal only if it names an implemented register.
  function automatic logic reg_in_range(input logic [FIELD_W-1:0] a, input int reg_count);
    return int'({1'b0, a}) < reg_count;
  endfunction

endpackage

// File: rtl/scalar_decode_issue_scoreboard.sv
// In-flight destination scoreboard: one busy bit per implemented register.
// Lookups see the bits after this cycle's writeback clear so a result
// returning in the same cycle unblocks a waiting instruction.
module scalar_scoreboard #(
  parameter int REGISTER_NUMBER = 16,
  parameter int ADDR_NUMBER     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_en,
  input  logic [ADDR_NUMBER-1:0] set_addr,
  input  logic                   clear_en,
  input  logic [ADDR_NUMBER-1:0] clear_addr,
  input  logic [ADDR_NUMBER-1:0] lookup_addr_1,
  input  logic [ADDR_NUMBER-1:0] lookup_addr_2,
  input  logic [ADDR_NUMBER-1:0] lookup_addr_3,
  output logic                   hit_1,
  output logic                   hit_2,
  output logic                   hit_3
);

  logic [REGISTER_NUMBER-1:0] busy;
  logic [REGISTER_NUMBER-1:0] visible;
  logic [REGISTER_NUMBER-1:0] set_mask;

  // Decode set/clear addresses into masks; out-of-range addresses match no bit.
  always_comb begin
    visible  = busy;
    set_mask = '0;
    for (int i = 0; i < REGISTER_NUMBER; i++) begin
      if (clear_en && clear_addr == ADDR_NUMBER'(i)) visible[i] = 1'b0;
      if (set_en && set_addr == ADDR_NUMBER'(i)) set_mask[i] = 1'b1;
    end
  end

  // Three lookups against the post-clear view.
  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    hit_3 = 1'b0;
    for (int i = 0; i < REGISTER_NUMBER; i++) begin
      if (lookup_addr_1 == ADDR_NUMBER'(i)) hit_1 = visible[i];
      if (lookup_addr_2 == ADDR_NUMBER'(i)) hit_2 = visible[i];
      if (lookup_addr_3 == ADDR_NUMBER'(i)) hit_3 = visible[i];
    end
  end

  // Busy bits update; a set on the same bit as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= visible | set_mask;
  end

endmodule

// File: rtl/scalar_decode_issue.sv
// Scalar decode/issue stage feeding the register file read ports and the
// execute stage. Stalls on RAW/WAW hazards using an in-flight scoreboard.
// Optional build macro SCALAR_STALL_COUNT_EN adds a saturating stall_count.
module scalar_decode_issue #(
  parameter int BIT_NUMBER      = 32,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [31:0]            in_instr,
  output logic                   in_ready,
  output logic [ADDR_NUMBER-1:0] src_addr_1,
  output logic [ADDR_NUMBER-1:0] src_addr_2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_op,
  output logic [ADDR_NUMBER-1:0] out_dest,
  output logic [31:0]            out_imm,
  output logic                   out_illegal,
  input  logic                   wb_valid,
  input  logic [ADDR_NUMBER-1:0] wb_addr,
  input  logic [BIT_NUMBER-1:0]  wb_data,
  output logic                   write_enable,
  output logic [ADDR_NUMBER-1:0] dest_addr,
  output logic [BIT_NUMBER-1:0]  write_data
`ifdef SCALAR_STALL_COUNT_EN
  ,
  output logic [15:0]            stall_count
`endif
);

  import scalar_decode_issue_pkg::*;

  logic [3:0]         dec_op;
  logic [FIELD_W-1:0] dec_rd;
  logic [FIELD_W-1:0] dec_rs1;
  logic [FIELD_W-1:0] dec_rs2;
  logic [IMM_W-1:0]   dec_imm;
  op_class_t          cls;
  logic               illegal;
  logic               hazard;
  logic               accept;
  logic               hit_rs1;
  logic               hit_rs2;
  logic               hit_rd;

  assign dec_op  = in_instr[OP_MSB:OP_LSB];
  assign dec_rd  = in_instr[RD_MSB:RD_LSB];
  assign dec_rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign dec_rs2 = in_instr[RS2_MSB:RS2_LSB];
  assign dec_imm = in_instr[IMM_MSB:IMM_LSB];
  assign cls     = classify_op(dec_op);

  // Classify the incoming word: illegal opcode or any used field out of range.
  always_comb begin
    illegal = !cls.legal_op
           || (cls.uses_rs1  && !reg_in_range(dec_rs1, REGISTER_NUMBER))
           || (cls.uses_rs2  && !reg_in_range(dec_rs2, REGISTER_NUMBER))
           || (cls.writes_rd && !reg_in_range(dec_rd, REGISTER_NUMBER));
    hazard  = !illegal
           && ((cls.uses_rs1 && hit_rs1)
            || (cls.uses_rs2 && hit_rs2)
            || (cls.writes_rd && hit_rd));
  end

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  scalar_scoreboard #(
    .REGISTER_NUMBER(REGISTER_NUMBER),
    .ADDR_NUMBER    (ADDR_NUMBER)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_en       (accept && !illegal && cls.writes_rd),
    .set_addr     (ADDR_NUMBER'(dec_rd)),
    .clear_en     (wb_valid),
    .clear_addr   (wb_addr),
    .lookup_addr_1(ADDR_NUMBER'(dec_rs1)),
    .lookup_addr_2(ADDR_NUMBER'(dec_rs2)),
    .lookup_addr_3(ADDR_NUMBER'(dec_rd)),
    .hit_1        (hit_rs1),
    .hit_2        (hit_rs2),
    .hit_3        (hit_rd)
  );

  assign write_enable = wb_valid;
  assign dest_addr    = wb_addr;
  assign write_data   = wb_data;

  // Issue register: loads on a legal accept, drains on out_ready, else holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
      src_addr_1  <= '0;
      src_addr_2  <= '0;
      out_op      <= '0;
      out_dest    <= '0;
      out_imm     <= '0;
    end else begin
      out_illegal <= accept && illegal;
      if (accept && !illegal) begin
        out_valid  <= 1'b1;
        src_addr_1 <= cls.uses_rs1 ? ADDR_NUMBER'(dec_rs1) : '0;
        src_addr_2 <= cls.uses_rs2 ? ADDR_NUMBER'(dec_rs2) : '0;
        out_op     <= dec_op;
        out_dest   <= ADDR_NUMBER'(dec_rd);
        out_imm    <= {{(32-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SCALAR_STALL_COUNT_EN
  // Count cycles where an offered word is refused, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         stall_count <= '0;
    else if (in_valid && !in_ready && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
`endif

endmodule
